// File: rtl/boot_rom_loader_if.sv
// ROM read port and RAM write port seen by the boot loader.
interface boot_rom_loader_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;

    // Loader side: drives addresses and the write strobe, reads ROM data.
    modport master (
        output rom_addr,
        input  rom_data,
        output ram_addr,
        output ram_wdata,
        output ram_we
    );

    // Memory side: answers ROM reads combinationally, accepts RAM writes.
    modport slave (
        input  rom_addr,
        output rom_data,
        input  ram_addr,
        input  ram_wdata,
        input  ram_we
    );
endinterface

// File: rtl/boot_rom_loader.sv
// Boot sequencer: copies a fixed image from program ROM into program RAM one
// byte per clock while holding the CPU in reset, then releases the CPU after
// a settle delay. A reload request while running repeats the whole sequence.
module boot_rom_loader #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned COPY_LEN    = 162,
    parameter int unsigned SRC_BASE    = 0,
    parameter int unsigned DST_BASE    = 0,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reload,
    boot_rom_loader_if.master         bus,
    output logic                      cpu_rst_n,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                checksum
);

    localparam int unsigned IdxW = ADDR_W + 1;
    localparam logic [IdxW-1:0]   LastIdx  = IdxW'((COPY_LEN > 0) ? COPY_LEN - 1 : 0);
    localparam logic [ADDR_W-1:0] SrcBase  = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DstBase  = ADDR_W'(DST_BASE);
    localparam logic [7:0]        HoldLast = 8'(HOLD_CYCLES);

    typedef enum logic [1:0] {StIdle, StCopy, StHold, StRun} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [7:0]        hold_cnt_q;
    logic [7:0]        checksum_q;
    logic [IdxW-1:0]   addr_idx;

    // Sequencer state, copy index, settle counter and running checksum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            checksum_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    idx_q      <= '0;
                    checksum_q <= '0;
                    hold_cnt_q <= '0;
                    state_q    <= (COPY_LEN > 0) ? StCopy : StHold;
                end
                StCopy: begin
                    checksum_q <= checksum_q + bus.rom_data;
                    idx_q      <= idx_q + IdxW'(1);
                    if (idx_q == LastIdx) begin
                        state_q    <= StHold;
                        hold_cnt_q <= '0;
                    end
                end
                StHold: begin
                    hold_cnt_q <= hold_cnt_q + 8'd1;
                    if (hold_cnt_q == HoldLast) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (reload) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outside COPY idx has already stepped past the last byte, so back off
    // by one to keep the addresses parked on the final write.
    always_comb begin
        addr_idx = idx_q;
        if (state_q != StCopy && idx_q != '0) begin
            addr_idx = idx_q - IdxW'(1);
        end
    end

    assign bus.rom_addr  = SrcBase + addr_idx[ADDR_W-1:0];
    assign bus.ram_addr  = DstBase + addr_idx[ADDR_W-1:0];
    assign bus.ram_wdata = bus.rom_data;
    assign bus.ram_we    = (state_q == StCopy);

    assign cpu_rst_n = (state_q == StRun);
    assign done      = (state_q == StRun);
    assign busy      = (state_q != StRun);
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_boot_rom_loader.sv
// Bench for boot_rom_loader: three configurations (defaults, empty image,
// address wrap) checked against a list-of-writes model built from the ROM.
module tb_boot_rom_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit [7:0] rom [4096];

    logic [2:0]        rst_n_v  = 3'b000;
    logic [2:0]        reload_v = 3'b000;
    logic [2:0]        cpu_rst_n_v;
    logic [2:0]        busy_v;
    logic [2:0]        done_v;
    logic [2:0]        we_v;
    logic [2:0][7:0]   csum_v;
    logic [2:0][11:0]  rom_addr_v;
    logic [2:0][11:0]  ram_addr_v;
    logic [2:0][7:0]   wdata_v;

    int cfg_src  [3] = '{0, 0, 4090};
    int cfg_dst  [3] = '{0, 0, 4094};
    int cfg_len  [3] = '{162, 0, 4};
    int cfg_hold [3] = '{4, 0, 4};

    boot_rom_loader_if #(.ADDR_W(12)) bus0 ();
    boot_rom_loader_if #(.ADDR_W(12)) bus1 ();
    boot_rom_loader_if #(.ADDR_W(12)) bus2 ();

    assign bus0.rom_data = rom[bus0.rom_addr];
    assign bus1.rom_data = rom[bus1.rom_addr];
    assign bus2.rom_data = rom[bus2.rom_addr];

    assign rom_addr_v[0] = bus0.rom_addr;
    assign rom_addr_v[1] = bus1.rom_addr;
    assign rom_addr_v[2] = bus2.rom_addr;
    assign ram_addr_v[0] = bus0.ram_addr;
    assign ram_addr_v[1] = bus1.ram_addr;
    assign ram_addr_v[2] = bus2.ram_addr;
    assign wdata_v[0]    = bus0.ram_wdata;
    assign wdata_v[1]    = bus1.ram_wdata;
    assign wdata_v[2]    = bus2.ram_wdata;
    assign we_v[0]       = bus0.ram_we;
    assign we_v[1]       = bus1.ram_we;
    assign we_v[2]       = bus2.ram_we;

    boot_rom_loader dut0 (
        .clk(clk), .rst_n(rst_n_v[0]), .reload(reload_v[0]), .bus(bus0.master),
        .cpu_rst_n(cpu_rst_n_v[0]), .busy(busy_v[0]), .done(done_v[0]), .checksum(csum_v[0])
    );

    boot_rom_loader #(.COPY_LEN(0), .HOLD_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n_v[1]), .reload(reload_v[1]), .bus(bus1.master),
        .cpu_rst_n(cpu_rst_n_v[1]), .busy(busy_v[1]), .done(done_v[1]), .checksum(csum_v[1])
    );

    boot_rom_loader #(.SRC_BASE(4090), .DST_BASE(4094), .COPY_LEN(4)) dut2 (
        .clk(clk), .rst_n(rst_n_v[2]), .reload(reload_v[2]), .bus(bus2.master),
        .cpu_rst_n(cpu_rst_n_v[2]), .busy(busy_v[2]), .done(done_v[2]), .checksum(csum_v[2])
    );

    int exp_addr [$];
    int exp_data [$];
    int exp_sum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected write list: byte i of the image goes from ROM src+i to RAM dst+i.
    task automatic build_model(input int k);
        exp_addr.delete();
        exp_data.delete();
        exp_sum = 0;
        for (int i = 0; i < cfg_len[k]; i++) begin
            exp_addr.push_back((cfg_dst[k] + i) % 4096);
            exp_data.push_back(int'(rom[(cfg_src[k] + i) % 4096]));
            exp_sum = (exp_sum + int'(rom[(cfg_src[k] + i) % 4096])) % 256;
        end
    endtask

    task automatic check_reset(input int k, input string tag);
        chk({tag, "/rom_addr"}, rom_addr_v[k], cfg_src[k]);
        chk({tag, "/ram_addr"}, ram_addr_v[k], cfg_dst[k]);
        chk({tag, "/ram_we"}, we_v[k], 0);
        chk({tag, "/cpu_rst_n"}, cpu_rst_n_v[k], 0);
        chk({tag, "/busy"}, busy_v[k], 1);
        chk({tag, "/done"}, done_v[k], 0);
        chk({tag, "/checksum"}, csum_v[k], 0);
    endtask

    // Called at the negedge of the first IDLE cycle; returns at the negedge
    // of the first RUN cycle. rl_mode: 0 quiet, 1 random reload noise,
    // 2 reload held high (left high on return).
    task automatic observe(input int k, input int rl_mode, input string tag);
        int n;
        int wc;
        bit seen_run;
        int limit;
        build_model(k);
        limit = cfg_len[k] + cfg_hold[k] + 20;
        chk({tag, "/idle_cpu"}, cpu_rst_n_v[k], 0);
        chk({tag, "/idle_busy"}, busy_v[k], 1);
        chk({tag, "/idle_we"}, we_v[k], 0);
        wc = 0;
        seen_run = 0;
        for (n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (we_v[k] === 1'b1) begin
                if (wc < exp_addr.size()) begin
                    chk({tag, "/wr_addr"}, ram_addr_v[k], exp_addr[wc]);
                    chk({tag, "/wr_data"}, wdata_v[k], exp_data[wc]);
                    chk({tag, "/rd_addr"}, rom_addr_v[k], (cfg_src[k] + wc) % 4096);
                    chk({tag, "/wr_slot"}, n, wc + 1);
                end else begin
                    chk({tag, "/extra_write"}, wc + 1, exp_addr.size());
                end
                wc++;
            end
            if (cpu_rst_n_v[k] === 1'b1) begin
                seen_run = 1;
                break;
            end
            chk({tag, "/busy_low_cpu"}, busy_v[k], 1);
            if (rl_mode == 1) reload_v[k] = ($urandom_range(0, 3) == 0);
        end
        if (rl_mode != 2) reload_v[k] = 1'b0;
        chk({tag, "/reached_run"}, seen_run, 1);
        chk({tag, "/latency"}, n, 2 + cfg_len[k] + cfg_hold[k]);
        chk({tag, "/writes"}, wc, cfg_len[k]);
        chk({tag, "/checksum"}, csum_v[k], exp_sum);
        chk({tag, "/done"}, done_v[k], 1);
        chk({tag, "/busy"}, busy_v[k], 0);
        chk({tag, "/run_we"}, we_v[k], 0);
    endtask

    task automatic check_run_stable(input int k, input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk({tag, "/cpu"}, cpu_rst_n_v[k], 1);
            chk({tag, "/we"}, we_v[k], 0);
            chk({tag, "/checksum"}, csum_v[k], exp_sum);
        end
    endtask

    task automatic pulse_reload(input int k, input string tag);
        reload_v[k] = 1'b1;
        @(negedge clk);
        reload_v[k] = 1'b0;
        chk({tag, "/cpu_falls"}, cpu_rst_n_v[k], 0);
    endtask

    initial begin
        bit found;
        rom[0]   = 8'hA0;
        rom[1]   = 8'h30;
        rom[161] = 8'h01;
        for (int i = 2; i < 161; i++) rom[i] = 8'($urandom);

        repeat (2) @(negedge clk);
        check_reset(0, "rst0");
        check_reset(1, "rst1");
        check_reset(2, "rst2");

        // Defaults: cold boot, then RUN must stay put.
        rst_n_v[0] = 1'b1;
        observe(0, 0, "dflt");
        check_run_stable(0, "dflt_run", 5);

        // Reload with random reload noise during COPY/HOLD.
        pulse_reload(0, "reload");
        observe(0, 1, "reload");
        check_run_stable(0, "reload_run", 3);

        // Reset dropped for one edge while idx is 50.
        pulse_reload(0, "mid");
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (we_v[0] === 1'b1 && ram_addr_v[0] == 12'd50) begin
                found = 1;
                break;
            end
        end
        chk("mid/reached_idx50", found, 1);
        rst_n_v[0] = 1'b0;
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        check_reset(0, "mid_rst");
        observe(0, 0, "mid");

        // Reload held high: one restart per RUN entry, one RUN cycle between.
        reload_v[0] = 1'b1;
        @(negedge clk);
        chk("b2b/cpu_falls", cpu_rst_n_v[0], 0);
        observe(0, 2, "b2b1");
        @(negedge clk);
        chk("b2b/single_run_cycle", cpu_rst_n_v[0], 0);
        observe(0, 2, "b2b2");
        reload_v[0] = 1'b0;
        check_run_stable(0, "b2b_run", 4);

        // Empty image, no settle delay.
        rst_n_v[1] = 1'b1;
        observe(1, 0, "len0");
        check_run_stable(1, "len0_run", 2);

        // Wrapping source and destination addresses.
        rst_n_v[2] = 1'b1;
        observe(2, 0, "wrap");
        pulse_reload(2, "wrap_rl");
        observe(2, 1, "wrap_rl");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boot_rom_loader.md
Name: boot_rom_loader

Overview:
- Boot sequencer for the blinky SoC. After reset it copies a fixed-length image from the 12-bit-addressed combinational program ROM into program RAM, one byte per clock.
- It holds the CPU in reset throughout the copy, then releases it after a programmable settle delay.
- A reload request re-runs the copy at any time after the CPU is running.
- Sits between the ROM, the RAM write port and the CPU reset input.

Parameters:
- ADDR_W, 12, width of ROM/RAM byte address
- COPY_LEN, 162, number of bytes copied (0..2^ADDR_W)
- SRC_BASE, 0, first ROM address read
- DST_BASE, 0, first RAM address written
- HOLD_CYCLES, 4, cycles cpu_rst_n stays low after last write (0..255)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- reload  in  1  single-cycle request to recopy image; honoured only in RUN
- rom_addr  out  ADDR_W  address to program ROM
- rom_data  in  8  combinational ROM read data for rom_addr
- ram_addr  out  ADDR_W  RAM write address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write enable; RAM samples on the rising edge
- cpu_rst_n  out  1  active-low CPU reset
- busy  out  1  high in IDLE, COPY and HOLD
- done  out  1  high in RUN
- checksum  out  8  mod-256 sum of bytes written in the last or current copy

Behaviour:
- One clock. Reset is synchronous and active-low: rst_n is sampled on the rising edge of clk; no asynchronous path.
- Reset state: state=IDLE, idx=0, hold_cnt=0, checksum=0.
- Output values while in reset:
  - rom_addr=SRC_BASE, ram_addr=DST_BASE
  - ram_we=0, cpu_rst_n=0, busy=1, done=0
- States: IDLE, COPY, HOLD, RUN. State, idx, hold_cnt and checksum are registered. All other outputs are decoded from the registers.
- IDLE:
  - Lasts exactly 1 cycle.
  - Next state is COPY if COPY_LEN>0, else HOLD.
  - On exit: idx=0, checksum=0, hold_cnt=0.
- COPY:
  - rom_addr=(SRC_BASE+idx) mod 2^ADDR_W; ram_addr=(DST_BASE+idx) mod 2^ADDR_W.
  - ram_wdata=rom_data, a combinational passthrough that is valid in the same cycle; ram_we=1.
  - Each edge: checksum += rom_data (8-bit wrap), idx += 1.
  - When idx==COPY_LEN-1 the state goes to HOLD with hold_cnt=0.
  - Exactly COPY_LEN write cycles occur, with consecutive addresses and no gaps. Address wrap past 2^ADDR_W-1 goes to 0.
- HOLD:
  - ram_we=0, cpu_rst_n=0.
  - hold_cnt increments each cycle.
  - When hold_cnt==HOLD_CYCLES the next state is RUN. HOLD therefore lasts HOLD_CYCLES+1 cycles.
- RUN:
  - cpu_rst_n=1, done=1, busy=0, ram_we=0.
  - rom_addr and ram_addr hold their last values.
  - checksum is stable.
- reload:
  - In RUN, reload=1 moves to IDLE on the next edge. cpu_rst_n is low from that cycle on and the full sequence repeats.
  - reload is ignored in IDLE, COPY and HOLD; it is not queued.
- rst_n low in any state, including mid-COPY, returns to the reset state on that edge. The partial copy is abandoned and restarts from idx 0.
- Latency: first cpu_rst_n=1 cycle is cycle 1+COPY_LEN+HOLD_CYCLES+1 after the first cycle with rst_n=1. With the defaults that is cycle 168.
- idx is wide enough to hold COPY_LEN (ADDR_W+1 bits).

Test Plan:
- Defaults, release reset:
  - ram_we is high for exactly 162 consecutive cycles.
  - Write 0 is addr 0 / data 0xA0; write 1 is addr 1 / data 0x30; last write is addr 161 / data 0x01.
  - cpu_rst_n rises on cycle 168.
  - checksum equals the bench model sum mod 256.
- COPY_LEN=0, HOLD_CYCLES=0: no ram_we pulse; cpu_rst_n rises 2 cycles after reset release; checksum=0.
- SRC_BASE=4090, DST_BASE=4094, COPY_LEN=4: write addresses are 4094, 4095, 0, 1, with data from ROM 4090..4093 (0x00 for unprogrammed locations).
- Reset mid-copy:
  - Drop rst_n at idx=50 for one edge: ram_we=0 and cpu_rst_n=0 on that edge.
  - After release the copy restarts at addr 0 and all 162 writes reoccur.
- Reload behaviour:
  - In RUN, pulse reload: cpu_rst_n falls on the next cycle and the copy repeats identically, with the same checksum.
  - A reload pulse during COPY or HOLD has no effect on timing.
- Back-to-back: reload asserted continuously in RUN causes a single restart per RUN entry. The CPU receives at least one cpu_rst_n=1 cycle between sequences.
